// File: rtl/spi_fir_bridge.sv
// SPI-slave command front end for an FIR core: deserialises framed commands,
// drives the core's coefficient/sample handshake and returns result and status on MISO.
module spi_fir_bridge #(
    parameter int DATA_W    = 12,
    parameter int COEFF_W   = 16,
    parameter int NUM_COEFF = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               sck,
    input  logic               mosi,
    input  logic               nss,
    output logic               miso,
    output logic [COEFF_W-1:0] fir_sample,
    output logic [COEFF_W-1:0] fir_coeff,
    output logic               load_coeff,
    output logic               data_ready,
    input  logic               modwait,
    input  logic [COEFF_W-1:0] fir_out,
    input  logic               err,
    output logic               frame_err,
    output logic [1:0]         debug
);
    localparam int F     = COEFF_W + 2;
    localparam int CNT_W = $clog2(F + 1);
    localparam int CC_W  = $clog2(NUM_COEFF + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ISSUE     = 2'b01,
        S_WAIT_BUSY = 2'b10,
        S_WAIT_DONE = 2'b11
    } state_t;

    state_t             r_state, w_next_state;
    logic [2:0]         r_sck_sh, r_nss_sh;
    logic [1:0]         r_mosi_sh;
    logic               r_rise, r_fall, r_nss_fall, r_nss_rise;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [F-2:0]       r_rx;
    logic [F-1:0]       r_tx;
    logic               r_pend_valid, r_pend_is_coeff;
    logic [COEFF_W-1:0] r_pend_data;
    logic               r_cur_is_coeff;
    logic [COEFF_W-1:0] r_fir_sample, r_fir_coeff, r_result;
    logic [1:0]         r_wait_cnt;
    logic [CC_W-1:0]    r_coeff_cnt;
    logic               r_err_sticky, r_overrun, r_not_loaded, r_frame_err, r_status_clr;

    logic               w_nss_low, w_frame_done, w_partial, w_cnt_full;
    logic [F-1:0]       w_frame;
    logic [1:0]         w_cmd;
    logic [COEFF_W-1:0] w_payload, w_res_nxt;
    logic               w_data_cmd, w_pend_busy, w_accept, w_overrun_set, w_notload_set, w_ferr_set;
    logic               w_err_nxt, w_ovr_nxt, w_nl_nxt, w_ferr_nxt;
    logic               w_capture, w_issue_start;

    // Pulses are registered one stage past the 2-FF synchronisers (3 clk pin-to-pulse).
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_sck_sh   <= '0;
            r_nss_sh   <= '0;
            r_mosi_sh  <= '0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_nss_fall <= 1'b0;
            r_nss_rise <= 1'b0;
        end else begin
            r_sck_sh   <= {r_sck_sh[1:0], sck};
            r_nss_sh   <= {r_nss_sh[1:0], nss};
            r_mosi_sh  <= {r_mosi_sh[0], mosi};
            r_rise     <= r_sck_sh[1] & ~r_sck_sh[2];
            r_fall     <= ~r_sck_sh[1] & r_sck_sh[2];
            r_nss_fall <= ~r_nss_sh[1] & r_nss_sh[2];
            r_nss_rise <= r_nss_sh[1] & ~r_nss_sh[2];
        end
    end

    assign w_nss_low    = ~r_nss_sh[2];
    assign w_frame      = {r_rx, r_mosi_sh[1]};
    assign w_cmd        = w_frame[F-1:F-2];
    assign w_payload    = w_frame[COEFF_W-1:0];
    assign w_frame_done = r_rise & w_nss_low & ~r_nss_fall & (r_bit_cnt == CNT_W'(F - 1));
    assign w_partial    = r_nss_rise & (r_bit_cnt != '0) & (r_bit_cnt != CNT_W'(F));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
        end else if (r_nss_fall) begin
            r_bit_cnt <= '0;
        end else if (r_rise && w_nss_low && r_bit_cnt != CNT_W'(F)) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_rx      <= {r_rx[F-3:0], r_mosi_sh[1]};
        end
    end

    // The entry being issued this cycle counts as free, so a coincident frame is kept.
    assign w_cnt_full    = (r_coeff_cnt == CC_W'(NUM_COEFF));
    assign w_data_cmd    = w_frame_done & ~w_cmd[1];
    assign w_pend_busy   = r_pend_valid & (r_state != S_ISSUE);
    assign w_accept      = w_data_cmd & ~w_pend_busy & (w_cmd[0] | w_cnt_full);
    assign w_overrun_set = w_data_cmd & w_pend_busy;
    assign w_notload_set = w_data_cmd & ~w_pend_busy & ~w_cmd[0] & ~w_cnt_full;
    assign w_ferr_set    = w_partial | (w_frame_done & (w_cmd == 2'b11));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_pend_valid    <= 1'b0;
            r_pend_is_coeff <= 1'b0;
            r_pend_data     <= '0;
        end else if (w_accept) begin
            r_pend_valid    <= 1'b1;
            r_pend_is_coeff <= w_cmd[0];
            r_pend_data     <= w_payload;
        end else if (r_state == S_ISSUE) begin
            r_pend_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        load_coeff   = 1'b0;
        data_ready   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE:      if (r_pend_valid && !modwait) w_next_state = S_ISSUE;
            S_ISSUE: begin
                load_coeff   = r_cur_is_coeff;
                data_ready   = ~r_cur_is_coeff;
                w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: if (modwait || r_wait_cnt == 2'd3) w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!modwait) begin
                    w_capture    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default:     w_next_state = S_IDLE;
        endcase
    end

    assign w_issue_start = (r_state == S_IDLE) && (w_next_state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cur_is_coeff <= 1'b0;
            r_fir_coeff    <= '0;
            r_fir_sample   <= '0;
            r_wait_cnt     <= '0;
            r_coeff_cnt    <= '0;
            r_result       <= '0;
        end else begin
            if (w_issue_start) begin
                r_cur_is_coeff <= r_pend_is_coeff;
                if (r_pend_is_coeff) r_fir_coeff  <= r_pend_data;
                else                 r_fir_sample <= COEFF_W'(r_pend_data[DATA_W-1:0]);
            end
            if (r_state == S_ISSUE)                       r_wait_cnt <= '0;
            else if (r_state == S_WAIT_BUSY && !modwait)  r_wait_cnt <= r_wait_cnt + 2'd1;
            // A coefficient arriving on a full set starts a fresh load.
            if (r_state == S_ISSUE && r_cur_is_coeff && w_cnt_full)
                r_coeff_cnt <= '0;
            else if (w_capture && r_cur_is_coeff && !w_cnt_full)
                r_coeff_cnt <= r_coeff_cnt + CC_W'(1);
            if (w_capture && !r_cur_is_coeff) r_result <= fir_out;
        end
    end

    assign w_res_nxt  = (w_capture && !r_cur_is_coeff) ? fir_out : r_result;
    assign w_err_nxt  = (r_err_sticky & ~r_status_clr) | (w_capture & ~r_cur_is_coeff & err);
    assign w_ovr_nxt  = (r_overrun & ~r_status_clr) | w_overrun_set;
    assign w_nl_nxt   = (r_not_loaded & ~r_status_clr) | w_notload_set;
    assign w_ferr_nxt = (r_frame_err & ~r_status_clr) | w_ferr_set;

    // Response loads the next-cycle flag/result values so a coincident capture is reported.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_status_clr <= 1'b0;
            r_err_sticky <= 1'b0;
            r_overrun    <= 1'b0;
            r_not_loaded <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tx         <= '0;
        end else begin
            r_status_clr <= w_frame_done & (w_cmd == 2'b10);
            r_err_sticky <= w_err_nxt;
            r_overrun    <= w_ovr_nxt;
            r_not_loaded <= w_nl_nxt;
            r_frame_err  <= w_ferr_nxt;
            if (r_nss_fall)
                r_tx <= {w_err_nxt, w_ovr_nxt | w_nl_nxt, w_res_nxt};
            else if (r_fall && w_nss_low)
                r_tx <= {r_tx[F-2:0], 1'b0};
        end
    end

    assign miso       = r_tx[F-1];
    assign fir_sample = r_fir_sample;
    assign fir_coeff  = r_fir_coeff;
    assign frame_err  = r_frame_err;
    assign debug      = r_state;

endmodule

// File: tb/tb_spi_fir_bridge.sv
// Directed bench for spi_fir_bridge: SPI master tasks, a small FIR core model
// (result = sample * sum of loaded coefficients) and hand-computed expectations.
module tb_spi_fir_bridge;
    logic        clk = 1'b0;
    logic        n_rst, sck, mosi, nss;
    logic        miso, load_coeff, data_ready, frame_err;
    logic [15:0] fir_sample, fir_coeff;
    logic [15:0] fir_out = '0;
    logic        err = 1'b0;
    logic [1:0]  debug;
    logic        core_busy = 1'b0;
    logic        force_busy = 1'b0;
    wire         modwait = core_busy | force_busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_load   = 0;
    int n_dr     = 0;
    logic [15:0] got_sample = '0;
    logic [15:0] got_coeff_q[$];
    logic [15:0] exp_q[$];

    int busy_len    = 3;
    int busy_cnt    = 0;
    int core_result = 0;
    int m_coeff[4]  = '{0, 0, 0, 0};
    int m_idx       = 0;

    spi_fir_bridge #(.DATA_W(12), .COEFF_W(16), .NUM_COEFF(4)) dut (
        .clk(clk), .n_rst(n_rst), .sck(sck), .mosi(mosi), .nss(nss), .miso(miso),
        .fir_sample(fir_sample), .fir_coeff(fir_coeff), .load_coeff(load_coeff),
        .data_ready(data_ready), .modwait(modwait), .fir_out(fir_out), .err(err),
        .frame_err(frame_err), .debug(debug)
    );

    always #5 clk = ~clk;

    // Strobe monitor: one count per high cycle, so a stretched pulse is visible.
    always @(negedge clk) begin
        if (load_coeff) begin
            n_load++;
            got_coeff_q.push_back(fir_coeff);
        end
        if (data_ready) begin
            n_dr++;
            got_sample = fir_sample;
        end
    end

    // Core model: busy for busy_len cycles after a strobe, result valid as busy drops.
    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                core_busy = 1'b0;
                fir_out   = core_result[15:0];
            end
        end else if (load_coeff) begin
            m_coeff[m_idx] = int'(fir_coeff);
            m_idx          = (m_idx + 1) % 4;
            core_busy      = 1'b1;
            busy_cnt       = busy_len;
            core_result    = int'(fir_out);
        end else if (data_ready) begin
            core_result = int'(fir_sample) * (m_coeff[0] + m_coeff[1] + m_coeff[2] + m_coeff[3]);
            core_busy   = 1'b1;
            busy_cnt    = busy_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mode-0 master: MOSI changes after sck falls, MISO is read just before sck rises.
    task automatic spi_frame(input logic [17:0] word, input int nbits, input bit end_frame,
                             output logic [17:0] rsp);
        rsp = '0;
        nss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[17-i];
            repeat (8) @(negedge clk);
            rsp[17-i] = miso;
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
        end
        repeat (8) @(negedge clk);
        if (end_frame) begin
            nss = 1'b1;
            repeat (30) @(negedge clk);
        end
    endtask

    task automatic spi_cmd(input logic [1:0] cmd, input logic [15:0] payload);
        logic [17:0] rsp;
        spi_frame({cmd, payload}, 18, 1'b1, rsp);
    endtask

    task automatic status_read(output logic [17:0] rsp);
        spi_frame({2'b10, 16'h0000}, 18, 1'b1, rsp);
    endtask

    task automatic load_coeffs_1to4(input string tag);
        logic [17:0] rsp;
        int base;
        base = n_load;
        got_coeff_q.delete();
        exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        for (int i = 1; i <= 4; i++) spi_frame({2'b01, 16'(i)}, 18, 1'b1, rsp);
        check({tag, "_n_load"}, n_load - base, 4);
        check({tag, "_n_got"}, got_coeff_q.size(), 4);
        while (exp_q.size() > 0 && got_coeff_q.size() > 0)
            check({tag, "_coeff_order"}, got_coeff_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        logic [17:0] rsp;
        int          base_l, base_d;
        bit          found;

        n_rst = 1'b0; sck = 1'b0; mosi = 1'b0; nss = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_ctrl", {miso, debug, load_coeff, data_ready, frame_err}, 0);
        check("rst_sample", fir_sample, 0);
        check("rst_coeff", fir_coeff, 0);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        // First response after reset is all zeros.
        spi_frame({2'b10, 16'h0000}, 18, 1'b1, rsp);
        check("rsp_after_rst", rsp, 18'h00000);
        load_coeffs_1to4("load1");

        base_d = n_dr;
        spi_cmd(2'b00, 16'h0ABC);
        check("sample_n_dr", n_dr - base_d, 1);
        check("sample_val", got_sample, 16'h0ABC);
        status_read(rsp);
        check("rsp_result", rsp, 18'h06B58);

        // Sample with no coefficients loaded is dropped and flagged.
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        base_d = n_dr;
        spi_cmd(2'b00, 16'h0123);
        check("unloaded_n_dr", n_dr - base_d, 0);
        status_read(rsp);
        check("rsp_not_loaded", rsp, 18'h10000);
        status_read(rsp);
        check("rsp_cleared", rsp, 18'h00000);

        // Busy core: first sample pends, second overruns.
        load_coeffs_1to4("load2");
        base_d = n_dr;
        force_busy = 1'b1;
        spi_cmd(2'b00, 16'hF005);
        spi_cmd(2'b00, 16'h0006);
        repeat (200) @(negedge clk);
        check("busy_no_dr", n_dr - base_d, 0);
        force_busy = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_n_dr", n_dr - base_d, 1);
        check("busy_sample", got_sample, 16'h0005);
        status_read(rsp);
        check("rsp_overrun", rsp, 18'h10032);
        status_read(rsp);
        check("rsp_ovr_cleared", rsp, 18'h00032);

        // Truncated frame and reserved command.
        base_l = n_load; base_d = n_dr;
        spi_frame({2'b01, 16'h1234}, 9, 1'b1, rsp);
        check("partial_ferr", frame_err, 1'b1);
        check("partial_no_strobe", (n_load - base_l) + (n_dr - base_d), 0);
        status_read(rsp);
        check("partial_rsp", rsp, 18'h00032);
        check("partial_ferr_clr", frame_err, 1'b0);
        spi_cmd(2'b11, 16'h5555);
        check("rsv_ferr", frame_err, 1'b1);
        check("rsv_no_strobe", (n_load - base_l) + (n_dr - base_d), 0);
        status_read(rsp);
        check("rsv_ferr_clr", frame_err, 1'b0);

        // Reset mid-frame after bit 7.
        spi_frame({2'b01, 16'h0077}, 7, 1'b0, rsp);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("midframe_rst_ctrl", {miso, debug, load_coeff, data_ready, frame_err}, 0);
        check("midframe_rst_sample", fir_sample, 0);
        check("midframe_rst_coeff", fir_coeff, 0);
        nss = 1'b1;
        repeat (30) @(negedge clk);
        check("midframe_no_ferr", frame_err, 1'b0);

        // Reset while waiting for the core to finish.
        busy_len = 200;
        base_l = n_load;
        spi_cmd(2'b01, 16'h0007);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (debug == 2'b11) found = 1'b1;
            else @(negedge clk);
        end
        check("wait_done_reached", found, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("waitdone_rst_debug", debug, 2'b00);
        check("waitdone_rst_coeff", fir_coeff, 0);
        base_l = n_load; base_d = n_dr;
        repeat (250) @(negedge clk);
        check("waitdone_no_strobe", (n_load - base_l) + (n_dr - base_d), 0);
        busy_len = 3;

        spi_cmd(2'b01, 16'h0009);
        check("post_rst_n_load", n_load - base_l, 1);
        check("post_rst_coeff", fir_coeff, 16'h0009);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
